// File: rtl/sd4_mac_pkg.sv
// Shared widths and helpers for the SD4 MAC block-floating-point datapath.
// Defaults match the standard 9-lane, 5-bit partial-product configuration.
package sd4_mac_pkg;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   localparam int unsigned LANES_D   = 9;
   localparam int unsigned PP_W_D    = 5;
   localparam int unsigned EXP_W_D   = 5;
   localparam int unsigned ALIGN_W_D = 16;
   localparam int unsigned ACC_W_D   = 24;
   localparam int unsigned SUM_W     = ALIGN_W_D + clog2(LANES_D);

endpackage

// File: rtl/sd4_lane_align.sv
// One lane of the alignment stage: MSB-align the partial product, then
// arithmetic right shift by the lane's exponent deficit (clamped).
module sd4_lane_align #(
   parameter int unsigned PP_W    = 5,
   parameter int unsigned EXP_W   = 5,
   parameter int unsigned ALIGN_W = 16
) (
   input  logic signed [PP_W-1:0]    pp,
   input  logic        [EXP_W-1:0]   lane_exp,
   input  logic        [EXP_W-1:0]   emax,
   output logic signed [ALIGN_W-1:0] aligned
);

   logic        [EXP_W-1:0]   diff;
   logic        [31:0]        shamt;
   logic signed [ALIGN_W-1:0] msb;

   always_comb begin
      diff  = emax - lane_exp;
      shamt = 32'(diff);
      if (shamt > ALIGN_W - 1) shamt = ALIGN_W - 1;
      msb     = {pp, {(ALIGN_W - PP_W){1'b0}}};
      aligned = msb >>> shamt;
   end

endmodule

// File: rtl/sd4_dot_accumulator.sv
// Streaming block-floating-point dot-product engine: S1 capture, S2 max/align,
// S3 adder tree, S4 accumulate, then a handshaked result register.
module sd4_dot_accumulator
   import sd4_mac_pkg::*;
#(
   parameter int unsigned LANES   = LANES_D,
   parameter int unsigned PP_W    = PP_W_D,
   parameter int unsigned EXP_W   = EXP_W_D,
   parameter int unsigned ALIGN_W = ALIGN_W_D,
   parameter int unsigned ACC_W   = ACC_W_D
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*PP_W-1:0]    in_pp,
   input  logic [LANES*EXP_W-1:0]   in_exp,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [ACC_W-1:0]  out_sum,
   output logic [EXP_W-1:0]         out_exp,
   output logic                     out_ovf
);

   localparam int unsigned SUM_WIDTH = ALIGN_W + clog2(LANES);
   localparam int unsigned LEAVES    = 1 << clog2(LANES);
   localparam int unsigned NODES     = 2 * LEAVES - 1;

   logic advance;

   // S1
   logic                   s1_valid_q, s1_valid_d;
   logic [LANES*PP_W-1:0]  s1_pp_q, s1_pp_d;
   logic [LANES*EXP_W-1:0] s1_exp_q, s1_exp_d;
   logic                   s1_last_q, s1_last_d;

   // S2
   logic [EXP_W-1:0]          s1_emax;
   logic signed [ALIGN_W-1:0] lane_a [LANES];
   logic                      s2_valid_q, s2_valid_d;
   logic signed [ALIGN_W-1:0] s2_a_q [LANES];
   logic signed [ALIGN_W-1:0] s2_a_d [LANES];
   logic [EXP_W-1:0]          s2_emax_q, s2_emax_d;
   logic                      s2_last_q, s2_last_d;

   // S3
   logic signed [SUM_WIDTH-1:0] node [NODES];
   logic                        s3_valid_q, s3_valid_d;
   logic signed [SUM_WIDTH-1:0] s3_sum_q, s3_sum_d;
   logic [EXP_W-1:0]            s3_emax_q, s3_emax_d;
   logic                        s3_last_q, s3_last_d;

   // S4
   logic [EXP_W-1:0]        acc_e;
   logic [31:0]             sh_acc, sh_sum;
   logic signed [ACC_W-1:0] acc_sh, sum_sh, acc_sat;
   logic signed [ACC_W:0]   acc_tot;
   logic                    sat_hit;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [EXP_W-1:0]        acc_exp_q, acc_exp_d;
   logic                    ovf_q, ovf_d;
   logic                    first_q, first_d;
   logic                    s4_done_q, s4_done_d;

   // Result
   logic                    out_valid_q, out_valid_d;
   logic signed [ACC_W-1:0] out_sum_q, out_sum_d;
   logic [EXP_W-1:0]        out_exp_q, out_exp_d;
   logic                    out_ovf_q, out_ovf_d;

   // Every stage holds while the result register is blocked.
   assign advance  = !(out_valid_q && !out_ready);
   assign in_ready = advance;

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_exp   = out_exp_q;
   assign out_ovf   = out_ovf_q;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_pp_d    = s1_pp_q;
      s1_exp_d   = s1_exp_q;
      s1_last_d  = s1_last_q;
      if (advance) begin
         s1_valid_d = in_valid;
         s1_pp_d    = in_pp;
         s1_exp_d   = in_exp;
         s1_last_d  = in_last;
      end
   end

   always_comb begin
      s1_emax = s1_exp_q[0 +: EXP_W];
      for (int unsigned i = 1; i < LANES; i++) begin
         if (s1_exp_q[i*EXP_W +: EXP_W] > s1_emax) s1_emax = s1_exp_q[i*EXP_W +: EXP_W];
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      sd4_lane_align #(
         .PP_W    (PP_W),
         .EXP_W   (EXP_W),
         .ALIGN_W (ALIGN_W)
      ) u_align (
         .pp       (s1_pp_q[g*PP_W +: PP_W]),
         .lane_exp (s1_exp_q[g*EXP_W +: EXP_W]),
         .emax     (s1_emax),
         .aligned  (lane_a[g])
      );
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_a_d     = s2_a_q;
      s2_emax_d  = s2_emax_q;
      s2_last_d  = s2_last_q;
      if (advance) begin
         s2_valid_d = s1_valid_q;
         s2_a_d     = lane_a;
         s2_emax_d  = s1_emax;
         s2_last_d  = s1_last_q;
      end
   end

   // Balanced tree over a power-of-two leaf set; unused leaves are zero.
   always_comb begin
      node = '{default: '0};
      for (int unsigned i = 0; i < LANES; i++) begin
         node[LEAVES-1+i] = SUM_WIDTH'(s2_a_q[i]);
      end
      for (int unsigned k = 0; k < LEAVES - 1; k++) begin
         node[LEAVES-2-k] = node[2*(LEAVES-2-k)+1] + node[2*(LEAVES-2-k)+2];
      end
   end

   always_comb begin
      s3_valid_d = s3_valid_q;
      s3_sum_d   = s3_sum_q;
      s3_emax_d  = s3_emax_q;
      s3_last_d  = s3_last_q;
      if (advance) begin
         s3_valid_d = s2_valid_q;
         s3_sum_d   = node[0];
         s3_emax_d  = s2_emax_q;
         s3_last_d  = s2_last_q;
      end
   end

   always_comb begin
      acc_e  = (s3_emax_q > acc_exp_q) ? s3_emax_q : acc_exp_q;
      sh_acc = 32'(acc_e - acc_exp_q);
      sh_sum = 32'(acc_e - s3_emax_q);
      if (sh_acc > ACC_W - 1) sh_acc = ACC_W - 1;
      if (sh_sum > ACC_W - 1) sh_sum = ACC_W - 1;
      acc_sh  = acc_q >>> sh_acc;
      sum_sh  = ACC_W'(s3_sum_q) >>> sh_sum;
      acc_tot = (ACC_W+1)'(acc_sh) + (ACC_W+1)'(sum_sh);
      sat_hit = acc_tot[ACC_W] ^ acc_tot[ACC_W-1];
      if (!sat_hit)         acc_sat = acc_tot[ACC_W-1:0];
      else if (acc_tot[ACC_W]) acc_sat = {1'b1, {(ACC_W-1){1'b0}}};
      else                  acc_sat = {1'b0, {(ACC_W-1){1'b1}}};
   end

   always_comb begin
      acc_d     = acc_q;
      acc_exp_d = acc_exp_q;
      ovf_d     = ovf_q;
      first_d   = first_q;
      s4_done_d = s4_done_q;
      if (advance) begin
         s4_done_d = s3_valid_q && s3_last_q;
         if (s3_valid_q) begin
            first_d = s3_last_q;
            if (first_q) begin
               acc_d     = ACC_W'(s3_sum_q);
               acc_exp_d = s3_emax_q;
               ovf_d     = 1'b0;
            end else begin
               acc_d     = acc_sat;
               acc_exp_d = acc_e;
               ovf_d     = ovf_q | sat_hit;
            end
         end
      end
   end

   // When advancing, any held result is being consumed, so a new load or a clear follows.
   always_comb begin
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_exp_d   = out_exp_q;
      out_ovf_d   = out_ovf_q;
      if (advance) begin
         out_valid_d = s4_done_q;
         if (s4_done_q) begin
            out_sum_d = acc_q;
            out_exp_d = acc_exp_q;
            out_ovf_d = ovf_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_pp_q     <= '0;
         s1_exp_q    <= '0;
         s1_last_q   <= 1'b0;
         s2_valid_q  <= 1'b0;
         for (int unsigned i = 0; i < LANES; i++) s2_a_q[i] <= '0;
         s2_emax_q   <= '0;
         s2_last_q   <= 1'b0;
         s3_valid_q  <= 1'b0;
         s3_sum_q    <= '0;
         s3_emax_q   <= '0;
         s3_last_q   <= 1'b0;
         acc_q       <= '0;
         acc_exp_q   <= '0;
         ovf_q       <= 1'b0;
         first_q     <= 1'b1;
         s4_done_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_exp_q   <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_pp_q     <= s1_pp_d;
         s1_exp_q    <= s1_exp_d;
         s1_last_q   <= s1_last_d;
         s2_valid_q  <= s2_valid_d;
         s2_a_q      <= s2_a_d;
         s2_emax_q   <= s2_emax_d;
         s2_last_q   <= s2_last_d;
         s3_valid_q  <= s3_valid_d;
         s3_sum_q    <= s3_sum_d;
         s3_emax_q   <= s3_emax_d;
         s3_last_q   <= s3_last_d;
         acc_q       <= acc_d;
         acc_exp_q   <= acc_exp_d;
         ovf_q       <= ovf_d;
         first_q     <= first_d;
         s4_done_q   <= s4_done_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_exp_q   <= out_exp_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

endmodule
